rf_write_arbiter: RTL and testbench

Shares the single register-file write port between the pipeline writeback stage (WB) and a multi-cycle multiply/divide unit (MD).
- WB has fixed priority and is never back-pressured.
- MD results are buffered in a small FIFO and drain into idle write cycles.
- The block also provides pending-write hazard flags to decode, and a starvation stall request to force a WB bubble.

---
 rtl/mips_pkg.sv | 15 +
 rtl/rf_wr_fifo.sv | 68 ++++++
 rtl/rf_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths, zero-register constant and write-request bundle
// for the register-file write path.
package mips_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Small circular buffer for multiply/divide results awaiting a free
// register-file write cycle; exposes per-entry valid/addr for hazard checks.
module rf_wr_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  wr_req_t                  i_wreq,
    input  logic                     i_pop,
    output wr_req_t                  o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [DEPTH-1:0]         o_vld,
    output logic [DEPTH-1:0][AW-1:0] o_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wr_req_t       r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] w_off [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wreq;
        end
    end

    // Entry i is live when its distance from the read pointer is below count
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_off[i]  = PW'(i) - r_rd_ptr;
            o_vld[i]  = ({1'b0, w_off[i]} < r_cnt);
            o_addr[i] = r_mem[i].addr;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: writeback has fixed priority, buffered
// multiply/divide results fill idle cycles, with hazard and starvation flags.
module rf_write_arbiter
    import mips_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          md_valid,
    output logic          md_ready,
    input  logic [AW-1:0] md_addr,
    input  logic [DW-1:0] md_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_data,
    input  logic [AW-1:0] q_addr1,
    input  logic [AW-1:0] q_addr2,
    input  logic [AW-1:0] q_addr3,
    output logic          pend_hit1,
    output logic          pend_hit2,
    output logic          pend_hit3,
    output logic          stall_req,
    output logic          err_waw
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    wr_req_t                  w_md_req;
    wr_req_t                  w_head;
    logic                     w_full;
    logic                     w_empty;
    logic [DEPTH-1:0]         w_vld;
    logic [DEPTH-1:0][AW-1:0] w_addrs;
    logic                     w_wb_act;
    logic                     w_push;
    logic                     w_grant_head;
    logic                     w_waw;
    logic [SW-1:0]            w_cnt_nxt;
    logic [SW-1:0]            r_starve_cnt;
    logic                     r_stall_req;
    logic                     r_err_waw;

    function automatic logic f_hit(
        input logic [DEPTH-1:0]         vld,
        input logic [DEPTH-1:0][AW-1:0] addrs,
        input logic [AW-1:0]            q
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (addrs[i] == q)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign w_md_req.addr = md_addr;
    assign w_md_req.data = md_data;

    rf_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wreq  (w_md_req),
        .i_pop   (w_grant_head),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_vld   (w_vld),
        .o_addr  (w_addrs)
    );

    // Ready uses pre-edge fullness only; a pop never frees a slot same-cycle
    assign md_ready = rst && !w_full;
    assign w_push   = md_valid && md_ready;
    assign w_wb_act = wb_we && (wb_addr != REG_ZERO);

    always_comb begin
        w_grant_head = 1'b0;
        rf_we        = 1'b0;
        rf_addr      = '0;
        rf_data      = '0;
        if (rst) begin
            if (w_wb_act) begin
                rf_we   = 1'b1;
                rf_addr = wb_addr;
                rf_data = wb_data;
            end else if (!w_empty) begin
                w_grant_head = 1'b1;
                rf_we        = (w_head.addr != REG_ZERO);
                rf_addr      = w_head.addr;
                rf_data      = w_head.data;
            end
        end
    end

    assign pend_hit1 = rst && (q_addr1 != REG_ZERO) &&
                       (f_hit(w_vld, w_addrs, q_addr1) ||
                        (w_push && (md_addr == q_addr1)));
    assign pend_hit2 = rst && (q_addr2 != REG_ZERO) &&
                       (f_hit(w_vld, w_addrs, q_addr2) ||
                        (w_push && (md_addr == q_addr2)));
    assign pend_hit3 = rst && (q_addr3 != REG_ZERO) &&
                       (f_hit(w_vld, w_addrs, q_addr3) ||
                        (w_push && (md_addr == q_addr3)));

    assign w_waw = w_wb_act && f_hit(w_vld, w_addrs, wb_addr);

    always_comb begin
        w_cnt_nxt = r_starve_cnt;
        if (w_empty || w_grant_head) begin
            w_cnt_nxt = '0;
        end else if (r_starve_cnt < SW'(STARVE_MAX)) begin
            w_cnt_nxt = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve_cnt <= '0;
            r_stall_req  <= 1'b0;
            r_err_waw    <= 1'b0;
        end else begin
            r_starve_cnt <= w_cnt_nxt;
            r_stall_req  <= (w_cnt_nxt >= SW'(STARVE_MAX));
            if (w_waw) begin
                r_err_waw <= 1'b1;
            end
        end
    end

    assign stall_req = r_stall_req;
    assign err_waw   = r_err_waw;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, drain, priority, backpressure,
// starvation, zero-register and WAW behaviour.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [4:0]  q1, q2, q3;
    logic        ph1, ph2, ph3;
    logic        stall_req;
    logic        err_waw;

    int n_tests = 0;
    int n_fail  = 0;

    rf_write_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .md_valid  (md_valid),
        .md_ready  (md_ready),
        .md_addr   (md_addr),
        .md_data   (md_data),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .q_addr1   (q1),
        .q_addr2   (q2),
        .q_addr3   (q3),
        .pend_hit1 (ph1),
        .pend_hit2 (ph2),
        .pend_hit3 (ph3),
        .stall_req (stall_req),
        .err_waw   (err_waw)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        md_valid = 1'b1; md_addr = 5'd4; md_data = 32'h1;
        q1 = 5'd4; q2 = '0; q3 = '0;

        // Reset with md_valid held high
        cyc(); cyc();
        #1;
        chk("rst_md_ready", md_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_err", err_waw, 0);
        chk("rst_pend", ph1, 0);
        rst = 1'b1; md_valid = 1'b0;
        #1;
        chk("rel_md_ready", md_ready, 1);
        chk("rel_rf_we", rf_we, 0);
        cyc();

        // Idle drain
        md_valid = 1'b1; md_addr = 5'd5; md_data = 32'hDEAD_BEEF; q1 = 5'd5;
        #1;
        chk("t2_no_bypass", rf_we, 0);
        chk("t2_pend_push", ph1, 1);
        cyc();
        md_valid = 1'b0;
        #1;
        chk("t2_we", rf_we, 1);
        chk("t2_addr", rf_addr, 5);
        chk("t2_data", rf_data, 32'hDEAD_BEEF);
        chk("t2_pend_head", ph1, 1);
        cyc();
        #1;
        chk("t2_idle_we", rf_we, 0);
        chk("t2_pend_clr", ph1, 0);

        // WB priority over a pending entry
        md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h77; q1 = 5'd7;
        #1;
        cyc();
        md_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_wb_we", rf_we, 1);
            chk("t3_wb_addr", rf_addr, 3);
            chk("t3_wb_data", rf_data, 32'h11);
            chk("t3_pend", ph1, 1);
            cyc();
        end
        wb_we = 1'b0;
        #1;
        chk("t3_md_we", rf_we, 1);
        chk("t3_md_addr", rf_addr, 7);
        chk("t3_md_data", rf_data, 32'h77);
        chk("t3_pend_last", ph1, 1);
        cyc();
        #1;
        chk("t3_pend_done", ph1, 0);
        chk("t3_idle_we", rf_we, 0);

        // Fill to full under continuous WB, then drain
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h22; q2 = 5'd12;
        md_valid = 1'b1; md_addr = 5'd10; md_data = 32'hA;
        #1;
        chk("t4_rdy0", md_ready, 1);
        cyc();
        md_addr = 5'd11; md_data = 32'hB;
        #1;
        chk("t4_rdy1", md_ready, 1);
        cyc();
        md_addr = 5'd12; md_data = 32'hC;
        #1;
        chk("t4_full", md_ready, 0);
        chk("t4_no_pend", ph2, 0);
        chk("t4_wb_addr", rf_addr, 3);
        cyc();
        wb_we = 1'b0;
        #1;
        chk("t4_pop_rdy", md_ready, 0);
        chk("t4_pop_addr", rf_addr, 10);
        chk("t4_pop_data", rf_data, 32'hA);
        cyc();
        #1;
        chk("t4_acc_rdy", md_ready, 1);
        chk("t4_acc_pend", ph2, 1);
        chk("t4_second_addr", rf_addr, 11);
        chk("t4_second_data", rf_data, 32'hB);
        cyc();
        md_valid = 1'b0;
        #1;
        chk("t4_third_we", rf_we, 1);
        chk("t4_third_addr", rf_addr, 12);
        chk("t4_third_data", rf_data, 32'hC);
        chk("t4_no_stall", stall_req, 0);
        cyc();
        #1;
        chk("t4_empty_we", rf_we, 0);

        // Starvation
        md_valid = 1'b1; md_addr = 5'd20; md_data = 32'h55; q1 = 5'd20;
        wb_we = 1'b1; wb_addr = 5'd3;
        #1;
        cyc();
        md_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t5_no_stall", stall_req, 0);
            cyc();
        end
        #1;
        chk("t5_stall", stall_req, 1);
        cyc();
        wb_we = 1'b0;
        #1;
        chk("t5_stall_hold", stall_req, 1);
        chk("t5_head_we", rf_we, 1);
        chk("t5_head_addr", rf_addr, 20);
        cyc();
        #1;
        chk("t5_stall_clr", stall_req, 0);
        chk("t5_idle_we", rf_we, 0);

        // WB to r0 lets the head through
        md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h99; q3 = 5'd9;
        #1;
        cyc();
        md_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1;
        #1;
        chk("t6_zero_we", rf_we, 1);
        chk("t6_zero_addr", rf_addr, 9);
        chk("t6_zero_data", rf_data, 32'h99);
        chk("t6_zero_pend", ph3, 1);
        cyc();
        wb_we = 1'b0; md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h98;
        #1;
        chk("t6_drained", rf_we, 0);
        cyc();

        // WAW against a pending entry
        md_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h2;
        #1;
        chk("t6_err_pre", err_waw, 0);
        chk("t6_waw_pend", ph3, 1);
        chk("t6_waw_data", rf_data, 32'h2);
        cyc();
        wb_we = 1'b0;
        #1;
        chk("t6_err_set", err_waw, 1);
        chk("t6_late_data", rf_data, 32'h98);
        cyc();
        #1;
        chk("t6_err_sticky", err_waw, 1);
        cyc();

        // MD entry to r0 pops without a write
        md_valid = 1'b1; md_addr = 5'd0; md_data = 32'h33; q1 = 5'd0;
        #1;
        cyc();
        md_valid = 1'b0;
        #1;
        chk("t6_r0_we", rf_we, 0);
        chk("t6_r0_pend", ph1, 0);
        cyc();

        // Reset mid-operation flushes the buffer
        md_valid = 1'b1; md_addr = 5'd15; md_data = 32'h44; q1 = 5'd15;
        #1;
        cyc();
        md_valid = 1'b0; rst = 1'b0;
        #1;
        chk("rm_we", rf_we, 0);
        chk("rm_pend", ph1, 0);
        chk("rm_rdy", md_ready, 0);
        cyc();
        rst = 1'b1;
        #1;
        chk("rm_err_clr", err_waw, 0);
        chk("rm_flush_we", rf_we, 0);
        chk("rm_flush_pend", ph1, 0);
        chk("rm_rdy_after", md_ready, 1);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
